// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational Skolem block and its spec checker.
// Optional first-counterexample capture is enabled by defining FIRST_CEX_EN.
`timescale 1ns/1ps
module skolem_sweep_ctrl #(
  parameter int N_IN   = 6,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  x_out,
  input  logic [N_OUT-1:0] y_in,
  input  logic             spec_ok,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             pass,
  output logic [N_IN:0]    fail_cnt,
  output logic [N_IN-1:0]  cex_x,
  output logic [N_OUT-1:0] cex_y
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  X_LAST    = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N_IN-1:0]  x_nx;
  logic [N_IN:0]    fail_nx;
  logic             busy_nx, done_nx, valid_nx, pass_nx;

  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      x_out    <= '0;
      fail_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      x_out    <= x_nx;
      fail_cnt <= fail_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      valid    <= valid_nx;
      pass     <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = x_out;
    fail_nx  = fail_cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    valid_nx = valid;
    pass_nx  = pass;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_DRIVE;
          cnt_nx   = SETTLE_LD;
          x_nx     = '0;
          fail_nx  = '0;
          valid_nx = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end else if (cnt == '0) begin
          state_nx = S_SAMPLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end else begin
          if (!spec_ok) fail_nx = sat_inc(fail_cnt);
          // The last vector's verdict is folded into pass on the same edge.
          if (x_out == X_LAST) begin
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            valid_nx = 1'b1;
            pass_nx  = (fail_nx == '0);
          end else begin
            state_nx = S_DRIVE;
            x_nx     = x_out + 1'b1;
            cnt_nx   = SETTLE_LD;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef FIRST_CEX_EN
  logic cex_armed;
  logic accept, sample_fail;

  assign accept      = (state == S_IDLE) && start && !abort;
  assign sample_fail = (state == S_SAMPLE) && !abort && !spec_ok;

  // Armed on each accepted start so only the first failure of a sweep is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cex_x     <= '0;
      cex_y     <= '0;
      cex_armed <= 1'b0;
    end else if (accept) begin
      cex_x     <= '0;
      cex_y     <= '0;
      cex_armed <= 1'b1;
    end else if (sample_fail && cex_armed) begin
      cex_x     <= x_out;
      cex_y     <= y_in;
      cex_armed <= 1'b0;
    end
  end
`else
  logic unused_y;
  assign unused_y = ^y_in;
  assign cex_x    = '0;
  assign cex_y    = '0;
`endif

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) checked
// every cycle against a timing model of the sweep, plus directed literal checks.
`timescale 1ns/1ps
module tb_skolem_sweep_ctrl;
  localparam int NV = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] abort = '0;
  logic [1:0] spec_ok, busy, done, valid, pass;
  logic [1:0][5:0] xo, cexx;
  logic [1:0][1:0] yi, cexy;
  logic [1:0][6:0] fc;
  int fm [2];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Failure modes: 0 none, 1 only vector 42, 2 every vector.
  function automatic bit vec_fails(input int mode, input int v);
    return (mode == 2) || (mode == 1 && v == 42);
  endfunction
  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int tlen(input int i);
    return NV * (settle_of(i) + 1);
  endfunction
  // Vector v is sampled on cycle (v+1)*(s+1) after start; its count shows one cycle later.
  function automatic int fails_seen(input int mode, input int s, input int j);
    int c = 0;
    for (int v = 0; v < NV; v++)
      if ((v + 1) * (s + 1) < j && vec_fails(mode, v)) c++;
    return c;
  endfunction
  function automatic int cex_x_exp(input int mode);
`ifdef FIRST_CEX_EN
    return (mode == 1) ? 42 : 0;
`else
    return 0 * mode;
`endif
  endfunction
  function automatic int cex_y_exp(input int mode);
`ifdef FIRST_CEX_EN
    return (mode == 1) ? 2 : 0;
`else
    return 0 * mode;
`endif
  endfunction

  assign spec_ok[0] = !vec_fails(fm[0], int'(xo[0]));
  assign spec_ok[1] = !vec_fails(fm[1], int'(xo[1]));
  assign yi[0] = xo[0][1:0];
  assign yi[1] = xo[1][1:0];

  skolem_sweep_ctrl #(.N_IN(6), .N_OUT(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .x_out(xo[0]), .y_in(yi[0]), .spec_ok(spec_ok[0]),
    .busy(busy[0]), .done(done[0]), .valid(valid[0]), .pass(pass[0]),
    .fail_cnt(fc[0]), .cex_x(cexx[0]), .cex_y(cexy[0]));

  skolem_sweep_ctrl #(.N_IN(6), .N_OUT(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .x_out(xo[1]), .y_in(yi[1]), .spec_ok(spec_ok[1]),
    .busy(busy[1]), .done(done[1]), .valid(valid[1]), .pass(pass[1]),
    .fail_cnt(fc[1]), .cex_x(cexx[1]), .cex_y(cexy[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model phases: 0 reset, 1 running (j = cycles since accepted start), 2 aborted, 3 results held.
  int ph [2];
  int jc [2];
  int mm [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i] <= 0;
        jc[i] <= 0;
      end else if (ph[i] == 1) begin
        if (jc[i] <= tlen(i) && abort[i]) ph[i] <= 2;
        else if (jc[i] == tlen(i) + 1) ph[i] <= 3;
        else jc[i] <= jc[i] + 1;
      end else if (start[i] && !abort[i]) begin
        ph[i] <= 1;
        jc[i] <= 1;
        mm[i] <= fm[i];
      end
    end
  end

  task automatic chk_results(input int i, input int exp_done);
    string p;
    int s;
    p = $sformatf("u%0d", i);
    s = settle_of(i);
    chk({p, " res done"}, done[i], exp_done);
    chk({p, " res busy"}, busy[i], 0);
    chk({p, " res valid"}, valid[i], 1);
    chk({p, " res fail_cnt"}, fc[i], fails_seen(mm[i], s, tlen(i) + 1));
    chk({p, " res pass"}, pass[i], (fails_seen(mm[i], s, tlen(i) + 1) == 0) ? 1 : 0);
    chk({p, " res x_out"}, xo[i], NV - 1);
    chk({p, " res cex_x"}, cexx[i], cex_x_exp(mm[i]));
    chk({p, " res cex_y"}, cexy[i], cex_y_exp(mm[i]));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string p;
      int s;
      p = $sformatf("u%0d", i);
      s = settle_of(i);
      case (ph[i])
        0: begin
          chk({p, " rst busy"}, busy[i], 0);
          chk({p, " rst done"}, done[i], 0);
          chk({p, " rst valid"}, valid[i], 0);
          chk({p, " rst pass"}, pass[i], 0);
          chk({p, " rst x_out"}, xo[i], 0);
          chk({p, " rst fail_cnt"}, fc[i], 0);
          chk({p, " rst cex_x"}, cexx[i], 0);
          chk({p, " rst cex_y"}, cexy[i], 0);
        end
        1: begin
          if (jc[i] <= tlen(i)) begin
            chk({p, " run busy"}, busy[i], 1);
            chk({p, " run done"}, done[i], 0);
            chk({p, " run valid"}, valid[i], 0);
            chk({p, " run x_out"}, xo[i], (jc[i] - 1) / (s + 1));
            chk({p, " run fail_cnt"}, fc[i], fails_seen(mm[i], s, jc[i]));
          end else begin
            chk_results(i, 1);
          end
        end
        2: begin
          chk({p, " abt busy"}, busy[i], 0);
          chk({p, " abt done"}, done[i], 0);
          chk({p, " abt valid"}, valid[i], 0);
        end
        default: chk_results(i, 0);
      endcase
    end
  end

  // Returns at the negedge where done is seen; bc counts busy cycles before it.
  task automatic wait_done(input int i, input int budget, output int bc);
    bit seen;
    seen = 1'b0;
    bc = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done[i]) seen = 1'b1;
      else begin
        if (busy[i]) bc++;
        @(negedge clk);
      end
    end
    if (!seen) chk($sformatf("u%0d done timeout", i), 0, 1);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  initial begin
    int bc, bc2, dn;
    bit hit;
    fm[0] = 0;
    fm[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy[0], 0);
    chk("reset fail_cnt", fc[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep
    pulse_start(0);
    wait_done(0, 300, bc);
    chk("t1 busy cycles", bc, 128);
    chk("t1 fail_cnt", fc[0], 0);
    chk("t1 pass", pass[0], 1);
    chk("t1 valid", valid[0], 1);
    @(negedge clk);
    chk("t1 done width", done[0], 0);

    // Single failing vector, start re-pulsed mid-sweep
    fm[0] = 1;
    pulse_start(0);
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[0]) bc++;
      start[0] = (k == 20);
      @(negedge clk);
    end
    start[0] = 1'b0;
    wait_done(0, 300, bc2);
    chk("t2 busy cycles", bc + bc2, 128);
    chk("t2 fail_cnt", fc[0], 1);
    chk("t2 pass", pass[0], 0);
`ifdef FIRST_CEX_EN
    chk("t2 cex_x", cexx[0], 42);
    chk("t2 cex_y", cexy[0], 2);
`endif
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    chk("t2 extra done", dn, 0);

    // start+abort together in idle, then every vector failing
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("t3 start+abort busy", busy[0], 0);
    chk("t3 start+abort valid", valid[0], 1);
    fm[0] = 2;
    pulse_start(0);
    wait_done(0, 300, bc);
    chk("t3 fail_cnt", fc[0], 7'h40);
    chk("t3 pass", pass[0], 0);
`ifdef FIRST_CEX_EN
    chk("t3 cex_x", cexx[0], 0);
`endif
    @(negedge clk);

    // Abort at vector 10, then a full sweep
    fm[0] = 0;
    pulse_start(0);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (xo[0] == 6'd10) hit = 1'b1;
      else @(negedge clk);
    end
    chk("t4 reached x10", hit, 1);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("t4 abort busy", busy[0], 0);
    chk("t4 abort valid", valid[0], 0);
    dn = done[0];
    repeat (5) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    chk("t4 abort done", dn, 0);
    pulse_start(0);
    wait_done(0, 300, bc);
    chk("t4 busy cycles", bc, 128);
    chk("t4 fail_cnt", fc[0], 0);
    chk("t4 pass", pass[0], 1);
    @(negedge clk);

    // Asynchronous reset mid-sweep
    fm[0] = 2;
    pulse_start(0);
    repeat (20) @(negedge clk);
    chk("t5 busy before reset", busy[0], 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5 async busy", busy[0], 0);
    chk("t5 async x_out", xo[0], 0);
    chk("t5 async fail_cnt", fc[0], 0);
    chk("t5 async valid", valid[0], 0);
    chk("t5 async done", done[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SETTLE=3 instance after reset
    fm[1] = 1;
    pulse_start(1);
    wait_done(1, 600, bc);
    chk("t6 busy cycles", bc, 256);
    chk("t6 fail_cnt", fc[1], 1);
    chk("t6 pass", pass[1], 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
Sequencer that exhaustively validates a synthesized Skolem function block (e.g. the 6-input / 2-output xnor Skolem formula) in hardware. It drives every input assignment onto the combinational Skolem circuit and waits a programmable settle time. It then samples an external specification checker's verdict and accumulates a failure count. It sits between the Skolem netlist plus spec checker and the test/host logic, which starts a sweep and reads the result.

Parameters:
N_IN, 6, number of Skolem inputs (universal variables); sweep covers 2^N_IN vectors
N_OUT, 2, number of Skolem outputs sampled back
SETTLE, 1, cycles x_out is held before sampling (minimum 1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep (accepted only in IDLE)
abort  input  1  cancel sweep in progress
x_out  output  N_IN  input vector driven to Skolem block
y_in  input  N_OUT  Skolem block outputs
spec_ok  input  1  spec checker verdict for (x_out, y_in), combinational
busy  output  1  high from sweep start until DONE/abort
done  output  1  one-cycle pulse when sweep completes
valid  output  1  results below belong to a completed sweep
pass  output  1  fail_cnt == 0, meaningful when valid
fail_cnt  output  N_IN+1  number of failing vectors (0..2^N_IN, never overflows)
cex_x  output  N_IN  first failing input vector (FIRST_CEX_EN only)
cex_y  output  N_OUT  Skolem outputs at first failure (FIRST_CEX_EN only)

Behaviour:
- Reset (async, rst_n low): state=IDLE; x_out=0, busy=0, done=0, valid=0, pass=0, fail_cnt=0, cex_x=0, cex_y=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 and abort=0 -> DRIVE; x_out=0, fail_cnt=0, valid=0, busy=1, cex capture re-armed. abort=1 in IDLE: stay IDLE (abort wins over start).
- DRIVE: hold x_out for SETTLE cycles (counter loaded SETTLE-1, counts down), then -> SAMPLE.
- SAMPLE (1 cycle): register spec_ok; if 0, fail_cnt+=1. If x_out == all-ones -> DONE, else x_out+=1 -> DRIVE.
- Per-vector cost SETTLE+1 cycles; full sweep = 2^N_IN*(SETTLE+1) cycles from first DRIVE cycle to DONE entry (128 at defaults).
- DONE (1 cycle): done=1, busy=0, valid=1, pass=(fail_cnt==0) (including the final vector's result); -> IDLE. Results hold until next accepted start.
- x_out does not wrap: last vector is all-ones; the counter never increments past it.
- start while busy: ignored, no effect on sweep.
- abort in DRIVE/SAMPLE: -> IDLE next cycle; busy=0, no done pulse, valid stays 0, fail_cnt holds partial value (undefined for checking). abort in DONE: done pulse still issued (sweep already complete).
- Reset mid-sweep: immediate return to reset values, no done.
- y_in sampled only in SAMPLE; unused otherwise.

Optional Feature:
FIRST_CEX_EN: when defined, first SAMPLE with spec_ok=0 in a sweep latches cex_x=x_out, cex_y=y_in; later failures do not overwrite; cleared to 0 on accepted start. When undefined, cex_x and cex_y are tied to 0 and no capture registers exist.

Test Plan:
- spec_ok tied 1, SETTLE=1, pulse start -> busy for 128 cycles, done pulse once, valid=1, pass=1, fail_cnt=0, x_out visits 0..63 in order.
- spec_ok=0 only when x_out==6'h2A, y_in=2'b10 -> fail_cnt=1, pass=0; with FIRST_CEX_EN cex_x=6'h2A, cex_y=2'b10.
- spec_ok tied 0 -> fail_cnt=64 (7'h40), pass=0; cex_x=6'h00 with FIRST_CEX_EN.
- abort asserted during x_out==6'd10 -> busy low next cycle, no done, valid=0; following start runs full sweep with fail_cnt restarting from 0.
- start re-pulsed mid-sweep and start+abort together in IDLE -> both ignored; sweep length unchanged, no second done.
- rst_n dropped asynchronously mid-sweep (between clk edges) -> all outputs at reset values immediately; SETTLE=3 run afterwards completes in 256 cycles.
